// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling floor and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int MIN_OVERSAMPLING = 2;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] word, input bit mode);
    logic p;
    p = ^word;
    return (mode == PARITY_MODE_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Optional 2-flop synchronizer followed by an optional rising-edge detector.
// With EDGE=0 the output is the (synchronized) level, with EDGE=1 a one-clk pulse.
module uart_sync_edge #(
  parameter bit SYNC    = 1'b1,
  parameter bit EDGE    = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);

  logic level;

  generate
    if (SYNC) begin : g_sync
      logic meta;
      logic stable;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta   <= RST_VAL;
          stable <= RST_VAL;
        end else begin
          meta   <= din;
          stable <= meta;
        end
      end
      assign level = stable;
    end else begin : g_bypass
      assign level = din;
    end

    if (EDGE) begin : g_edge
      logic level_d;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) level_d <= RST_VAL;
        else      level_d <= level;
      end
      assign q = level & ~level_d;
    end else begin : g_level
      assign q = level;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: start detect, mid-bit sampling on oversampling ticks,
// parity/stop checking and one-cycle result strobes.
//
// state      | meaning
// IDLE       | waiting for synced rx low
// START      | confirming the start bit at half a bit time
// DATA       | sampling DATA_BITS data bits, LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling the stop bit and issuing the result
// WAIT_IDLE  | framing error seen, waiting for the line to return high
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = PARITY_MODE_EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oversampling_clk,
  input  logic [4:0]           oversampling_factor,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [4:0] FAC_MIN  = 5'(MIN_OVERSAMPLING);

  logic rx_s;
  logic tick;

  uart_sync_edge #(.SYNC(1'b1), .EDGE(1'b0), .RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .din (rx),
    .q   (rx_s)
  );

  uart_sync_edge #(.SYNC(1'b0), .EDGE(1'b1), .RST_VAL(1'b0)) u_tick_edge (
    .clk (clk),
    .rst (rst),
    .din (oversampling_clk),
    .q   (tick)
  );

  rx_state_t            state_q, state_d;
  logic [4:0]           fac_q, fac_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 dv_d, fe_d, pe_d;
  logic                 half_pt, sample_pt;

  assign half_pt   = tick && (cnt_q == ((fac_q >> 1) - 5'd1));
  assign sample_pt = tick && (cnt_q == (fac_q - 5'd1));

  always_comb begin
    state_d   = state_q;
    fac_d     = fac_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    data_d    = data;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;

    if (tick && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
      cnt_d = cnt_q + 5'd1;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          fac_d     = (oversampling_factor < FAC_MIN) ? FAC_MIN : oversampling_factor;
          cnt_d     = 5'd0;
          bit_d     = 4'd0;
          par_bad_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (half_pt) begin
          cnt_d   = 5'd0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_pt) begin
          cnt_d   = 5'd0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          else                   bit_d   = bit_q + 4'd1;
        end
      end
      ST_PARITY: begin
        if (sample_pt) begin
          cnt_d     = 5'd0;
          par_bad_d = (rx_s != parity_bit(8'(shreg_q), PARITY_ODD));
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_pt) begin
          cnt_d  = 5'd0;
          data_d = shreg_q;
          if (rx_s) begin
            dv_d    = ~par_bad_q;
            pe_d    = par_bad_q;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            pe_d    = par_bad_q;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      fac_q         <= FAC_MIN;
      cnt_q         <= 5'd0;
      bit_q         <= 4'd0;
      shreg_q       <= '0;
      par_bad_q     <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fac_q         <= fac_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      par_bad_q     <= par_bad_d;
      data          <= data_d;
      data_valid    <= dv_d;
      framing_error <= fe_d;
      parity_error  <= pe_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: one plain receiver and one even-parity receiver,
// a frame table plus hand-written false-start, back-to-back and reset sequences.
module tb_uart_rx_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       osc = 1'b0;
  logic [4:0] factor = 5'd16;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;

  logic [7:0] data0, data1;
  logic       dv0, fe0, pe0, busy0;
  logic       dv1, fe1, pe1, busy1;

  uart_rx_sampler #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .oversampling_clk    (osc),
    .oversampling_factor (factor),
    .rx                  (rx0),
    .data                (data0),
    .data_valid          (dv0),
    .framing_error       (fe0),
    .parity_error        (pe0),
    .busy                (busy0)
  );

  uart_rx_sampler #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk                 (clk),
    .rst                 (rst),
    .oversampling_clk    (osc),
    .oversampling_factor (factor),
    .rx                  (rx1),
    .data                (data1),
    .data_valid          (dv1),
    .framing_error       (fe1),
    .parity_error        (pe1),
    .busy                (busy1)
  );

  always #5 clk = ~clk;

  // One tick per 4 clk: oversampling_clk high 1 cycle, low 3.
  int ph = 0;
  always @(negedge clk) begin
    ph  = (ph + 1) % 4;
    osc = (ph == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    bit         sel;
    int         fac;
    logic [7:0] d;
    int         par_mode;   // 0 none, 1 correct bit, 2 wrong bit
    int         stop_low;   // 0 good stop, else bit times held low
    logic       dv;
    logic       fe;
    logic       pe;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   dv_times[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  logic [7:0] last_data0 = 8'h00;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input bit sel, input logic [7:0] d, input logic dv,
                              input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.dv = dv; e.fe = fe; e.pe = pe;
    if (sel) q1.push_back(e);
    else begin
      q0.push_back(e);
      last_data0 = d;
    end
  endtask

  task automatic mon(input bit sel, input logic [7:0] d, input logic dv, input logic fe,
                     input logic pe, input logic prev);
    exp_t e;
    bit   have;
    if (!(dv | fe | pe)) return;
    n_tests++;
    if (prev) begin
      n_fail++;
      $display("FAIL strobe_width dut%0d: strobe high two cycles", sel);
    end
    n_tests++;
    if (dv && fe) begin
      n_fail++;
      $display("FAIL dv_fe_excl dut%0d: data_valid and framing_error together", sel);
    end
    have = 1'b0;
    if (sel) begin
      if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
    end else begin
      if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
    end
    n_tests++;
    if (!have) begin
      n_fail++;
      $display("FAIL unexpected_strobe dut%0d: data=%0h dv=%0b fe=%0b pe=%0b", sel, d, dv, fe, pe);
    end else if ({d, dv, fe, pe} !== {e.d, e.dv, e.fe, e.pe}) begin
      n_fail++;
      $display("FAIL frame dut%0d: got data=%0h dv=%0b fe=%0b pe=%0b expected data=%0h dv=%0b fe=%0b pe=%0b",
               sel, d, dv, fe, pe, e.d, e.dv, e.fe, e.pe);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(1'b0, data0, dv0, fe0, pe0, prev0);
      mon(1'b1, data1, dv1, fe1, pe1, prev1);
      if (dv0) dv_times.push_back(cyc);
    end
    prev0 = dv0 | fe0 | pe0;
    prev1 = dv1 | fe1 | pe1;
  end

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx1 = v;
    else     rx0 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int fac,
                            input int par_mode, input int stop_low);
    int         bt;
    logic [7:0] dd;
    bt = ((fac < 2) ? 2 : fac) * 4;
    dd = d;
    drive_bit(sel, 1'b0, bt);
    for (int i = 0; i < 8; i++) drive_bit(sel, dd[i], bt);
    if (par_mode != 0) drive_bit(sel, (^dd) ^ (par_mode == 2), bt);
    if (stop_low > 0) drive_bit(sel, 1'b0, stop_low * bt);
    else              drive_bit(sel, 1'b1, bt);
    if (sel) rx1 = 1'b1;
    else     rx0 = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int diff;
    vecs[0] = '{1'b0, 16, 8'hA5, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16, 8'h3C, 0, 3, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16, 8'h01, 2, 0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16, 8'h01, 1, 0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1,  8, 8'h3C, 1, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1,  8, 8'h80, 2, 1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0,  1, 8'h5A, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0,  3, 8'hC3, 0, 0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 31, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_dut0", {data0, dv0, fe0, pe0, busy0}, 32'h0);
    check("reset_dut1", {data1, dv1, fe1, pe1, busy1}, 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      factor = 5'(vecs[i].fac);
      expect_frame(vecs[i].sel, vecs[i].d, vecs[i].dv, vecs[i].fe, vecs[i].pe);
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].fac, vecs[i].par_mode, vecs[i].stop_low);
      @(negedge clk);
      check($sformatf("busy_after_stop[%0d]", i), vecs[i].sel ? busy1 : busy0, vecs[i].fe);
      repeat (4) @(negedge clk);
      check($sformatf("busy_idle[%0d]", i), vecs[i].sel ? busy1 : busy0, 1'b0);
      check($sformatf("data_hold[%0d]", i), vecs[i].sel ? data1 : data0, vecs[i].d);
      check($sformatf("queue_drained[%0d]", i), vecs[i].sel ? q1.size() : q0.size(), 0);
      repeat (20) @(negedge clk);
    end

    // False start: 4 ticks low, then back high before the half-bit check.
    factor = 5'd16;
    rx0 = 1'b0;
    repeat (10) @(negedge clk);
    check("false_start_busy", busy0, 1'b1);
    repeat (6) @(negedge clk);
    rx0 = 1'b1;
    repeat (60) @(negedge clk);
    check("false_start_idle", busy0, 1'b0);
    check("false_start_data", data0, last_data0);

    // Back-to-back frames at factor 8 with the factor disturbed mid-frame.
    factor = 5'd8;
    dv_times.delete();
    expect_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    expect_frame(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    fork
      begin
        send_frame(1'b0, 8'h55, 8, 0, 0);
        send_frame(1'b0, 8'hFF, 8, 0, 0);
      end
      begin
        repeat (100) @(negedge clk);
        factor = 5'd16;
        repeat (200) @(negedge clk);
        factor = 5'd8;
      end
    join
    repeat (6) @(negedge clk);
    check("b2b_dv_count", dv_times.size(), 2);
    diff = (dv_times.size() >= 2) ? (dv_times[1] - dv_times[0]) : 0;
    n_tests++;
    if (diff < 316 || diff > 324) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles expected 320", diff);
    end
    check("b2b_data", data0, 8'hFF);
    check("b2b_queue", q0.size(), 0);
    repeat (20) @(negedge clk);

    // Reset during the 4th data bit aborts the frame.
    factor = 5'd16;
    fork
      send_frame(1'b0, 8'hF0, 16, 0, 0);
      begin
        repeat (288) @(negedge clk);
        check("pre_reset_busy", busy0, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_reset_dut0", {data0, dv0, fe0, pe0, busy0}, 32'h0);
        check("mid_reset_dut1", {dv1, fe1, pe1, busy1}, 32'h0);
      end
    join
    repeat (5) @(negedge clk);
    rst = 1'b1;
    last_data0 = 8'h00;
    repeat (20) @(negedge clk);
    check("post_reset_data", data0, 8'h00);
    expect_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 8'h81, 16, 0, 0);
    repeat (5) @(negedge clk);
    check("post_reset_frame_data", data0, 8'h81);
    check("post_reset_busy", busy0, 1'b0);

    repeat (20) @(negedge clk);
    check("final_queue0", q0.size(), 0);
    check("final_queue1", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
